// File: rtl/ama_riscv_hazard_tracker_pkg.sv
// Shared types and constants for the hazard tracker and its perf counter.
package ama_riscv_hazard_tracker_pkg;

  localparam int          STALL_CNT_W = 16;
  localparam logic [5:0]  RF_X0_ZERO  = 6'd0;

  // RUN: normal flow. MEM_WAIT: a load in MEM is waiting on DMEM.
  typedef enum logic {
    HZ_STATE_RUN      = 1'b0,
    HZ_STATE_MEM_WAIT = 1'b1
  } hz_state_e;

  // Destination-register slot carried down the pipeline.
  typedef struct packed {
    logic [5:0] rd;
    logic       reg_we;
    logic       load;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{rd: 6'd0, reg_we: 1'b0, load: 1'b0};

endpackage

// File: rtl/ama_riscv_sat_counter.sv
// Saturating up-counter; increments on enabled edges, sticks at all-ones.
module ama_riscv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: add one when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ama_riscv_hazard_tracker.sv
// Destination-register pipeline (ID->EX->MEM), load-use bubble insertion
// and DMEM-wait freeze, with a saturating stall-cycle counter.
//
// Handshake: dmem_ready is a level from DMEM; while a writing load sits in
// MEM and dmem_ready=0 the whole pipeline freezes. The first cycle with
// dmem_ready=1 is a normal advancing cycle. flush_ex must be held by its
// source across a freeze, since it is ignored while frozen.
module ama_riscv_hazard_tracker
  import ama_riscv_hazard_tracker_pkg::*;
#(
  parameter int         CNT_W = STALL_CNT_W,
  parameter logic [5:0] RF_X0 = RF_X0_ZERO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       rs1_id,
  input  logic [5:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [5:0]       rd_id,
  input  logic             reg_we_id,
  input  logic             load_inst_id,
  input  logic             flush_ex,
  input  logic             dmem_ready,
  output logic [5:0]       rd_ex,
  output logic             reg_we_ex,
  output logic             load_ex,
  output logic [5:0]       rd_mem,
  output logic             reg_we_mem,
  output logic             stall_if_id,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_e state_q, state_d;
  stage_t    ex_q, ex_d;
  stage_t    mem_q, mem_d;
  logic      lu_haz;
  logic      mem_wait;

  // Hazard detection. x0 is never marked written, so the reg_we check
  // alone excludes it; the explicit rd check keeps the intent visible.
  always_comb begin
    lu_haz = ex_q.load && ex_q.reg_we && (ex_q.rd != RF_X0) &&
             ((rs1_used_id && (rs1_id == ex_q.rd)) ||
              (rs2_used_id && (rs2_id == ex_q.rd)));
    mem_wait = mem_q.load && mem_q.reg_we && !dmem_ready;
    freeze   = mem_wait;
    // A flushed ID instruction is dead, so let the redirect be fetched.
    stall_if_id = freeze || (lu_haz && !flush_ex);
  end

  // FSM next state: enter MEM_WAIT while DMEM stalls, leave on ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_STATE_RUN:      if (mem_wait)  state_d = HZ_STATE_MEM_WAIT;
      HZ_STATE_MEM_WAIT: if (!mem_wait) state_d = HZ_STATE_RUN;
      default:           state_d = HZ_STATE_RUN;
    endcase
  end

  // Stage advance: freeze holds everything, else shift and fill EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d = ex_q;
      if (flush_ex || lu_haz) begin
        ex_d = STAGE_BUBBLE;
      end else begin
        ex_d.rd     = rd_id;
        ex_d.reg_we = reg_we_id && (rd_id != RF_X0);
        ex_d.load   = load_inst_id;
      end
    end
  end

  // State and stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_STATE_RUN;
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
    end
  end

  ama_riscv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_if_id),
    .count (stall_cnt)
  );

  assign rd_ex      = ex_q.rd;
  assign reg_we_ex  = ex_q.reg_we;
  assign load_ex    = ex_q.load;
  assign rd_mem     = mem_q.rd;
  assign reg_we_mem = mem_q.reg_we;

endmodule

// File: tb/tb_ama_riscv_hazard_tracker.sv
// Directed bench for the hazard tracker with an expected-value queue.
module tb_ama_riscv_hazard_tracker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       rs1_id, rs2_id, rd_id;
  logic             rs1_used_id, rs2_used_id, reg_we_id, load_inst_id;
  logic             flush_ex, dmem_ready;
  logic [5:0]       rd_ex, rd_mem;
  logic             reg_we_ex, load_ex, reg_we_mem, stall_if_id, freeze;
  logic [CNT_W-1:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // {rd_ex, reg_we_ex, load_ex, rd_mem, reg_we_mem, stall_cnt}
  logic [30:0] exp_q[$];

  ama_riscv_hazard_tracker #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_used_id  (rs1_used_id),
    .rs2_used_id  (rs2_used_id),
    .rd_id        (rd_id),
    .reg_we_id    (reg_we_id),
    .load_inst_id (load_inst_id),
    .flush_ex     (flush_ex),
    .dmem_ready   (dmem_ready),
    .rd_ex        (rd_ex),
    .reg_we_ex    (reg_we_ex),
    .load_ex      (load_ex),
    .rd_mem       (rd_mem),
    .reg_we_mem   (reg_we_mem),
    .stall_if_id  (stall_if_id),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [5:0] r1, input logic [5:0] r2, input logic u1,
                     input logic u2, input logic [5:0] rd, input logic we,
                     input logic ld, input logic fl, input logic dr);
    rs1_id = r1; rs2_id = r2; rs1_used_id = u1; rs2_used_id = u2;
    rd_id = rd; reg_we_id = we; load_inst_id = ld; flush_ex = fl; dmem_ready = dr;
  endtask

  // Check combinational outputs for the driven inputs, queue the expected
  // post-edge register contents, clock once, then pop and compare.
  task automatic step(input string tag, input logic e_stall, input logic e_frz,
                      input logic [5:0] e_rd_ex, input logic e_we_ex, input logic e_ld_ex,
                      input logic [5:0] e_rd_mem, input logic e_we_mem,
                      input logic [CNT_W-1:0] e_cnt);
    logic [30:0] exp_v;
    #1;
    chk({tag, " stall_if_id"}, {31'd0, stall_if_id}, {31'd0, e_stall});
    chk({tag, " freeze"},      {31'd0, freeze},      {31'd0, e_frz});
    exp_q.push_back({e_rd_ex, e_we_ex, e_ld_ex, e_rd_mem, e_we_mem, e_cnt});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    chk({tag, " regs"},
        {1'b0, rd_ex, reg_we_ex, load_ex, rd_mem, reg_we_mem, stall_cnt},
        {1'b0, exp_v});
  endtask

  initial begin
    rst_n = 1'b0;
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #12;
    chk("reset regs", {1'b0, rd_ex, reg_we_ex, load_ex, rd_mem, reg_we_mem, stall_cnt}, 32'd0);
    chk("reset stall", {30'd0, stall_if_id, freeze}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain write of x5 flows EX then MEM with no stall.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t1 wr5 ex",   1'b0, 1'b0, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 16'd0);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t2 wr5 mem",  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b1, 16'd0);

    // Load x7 then a reader of x7: one bubble, then load sits in MEM.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t3 ld7",      1'b0, 1'b0, 6'd7, 1'b1, 1'b1, 6'd0, 1'b0, 16'd0);
    drv(6'd7, 6'd0, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t4 lu bubble", 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1, 16'd1);
    step("t5 lu resume", 1'b0, 1'b0, 6'd8, 1'b1, 1'b0, 6'd0, 1'b0, 16'd1);

    // Load to x0 followed by a reader of x0: never a hazard.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t6 ld x0",    1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd8, 1'b1, 16'd1);
    drv(6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t7 rd x0",    1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 16'd1);

    // Load x3 reaches MEM, DMEM holds off for 4 cycles.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t8 ld3",      1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 6'd0, 1'b0, 16'd1);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t9 ld3 mem",  1'b0, 1'b0, 6'd9, 1'b1, 1'b0, 6'd3, 1'b1, 16'd1);
    step("t10 frz",     1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 6'd3, 1'b1, 16'd2);
    step("t11 frz",     1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 6'd3, 1'b1, 16'd3);
    step("t12 frz",     1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 6'd3, 1'b1, 16'd4);
    step("t13 frz",     1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 6'd3, 1'b1, 16'd5);
    dmem_ready = 1'b1;
    step("t14 ready",   1'b0, 1'b0, 6'd9, 1'b1, 1'b0, 6'd9, 1'b1, 16'd5);

    // Flush coinciding with a load-use hazard on rs2: single bubble, no stall.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t15 ld4",     1'b0, 1'b0, 6'd4, 1'b1, 1'b1, 6'd9, 1'b1, 16'd5);
    drv(6'd0, 6'd4, 1'b0, 1'b1, 6'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    step("t16 flush lu", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd4, 1'b1, 16'd5);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t17 redirect", 1'b0, 1'b0, 6'd11, 1'b1, 1'b0, 6'd0, 1'b0, 16'd5);

    // Matching indices but operands not used: no hazard.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd12, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t18 ld12",    1'b0, 1'b0, 6'd12, 1'b1, 1'b1, 6'd11, 1'b1, 16'd5);
    drv(6'd12, 6'd12, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t19 unused",  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd12, 1'b1, 16'd5);

    // Freeze and load-use together (flush held during freeze is ignored);
    // the hazard takes effect once the freeze clears.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd13, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t20 ld13",    1'b0, 1'b0, 6'd13, 1'b1, 1'b1, 6'd0, 1'b0, 16'd5);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd14, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t21 ld14",    1'b0, 1'b0, 6'd14, 1'b1, 1'b1, 6'd13, 1'b1, 16'd5);
    drv(6'd14, 6'd0, 1'b1, 1'b0, 6'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t22 frz+lu",  1'b1, 1'b1, 6'd14, 1'b1, 1'b1, 6'd13, 1'b1, 16'd6);
    drv(6'd14, 6'd0, 1'b1, 1'b0, 6'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t23 lu after", 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd14, 1'b1, 16'd7);
    step("t24 resume",  1'b0, 1'b0, 6'd15, 1'b1, 1'b0, 6'd0, 1'b0, 16'd7);

    // Asynchronous reset in the middle of a freeze.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t25 ld3",     1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 6'd15, 1'b1, 16'd7);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t26 ld3 mem", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 16'd7);
    dmem_ready = 1'b0;
    #1;
    chk("pre-rst freeze", {31'd0, freeze}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst regs", {1'b0, rd_ex, reg_we_ex, load_ex, rd_mem, reg_we_mem, stall_cnt}, 32'd0);
    chk("async rst stall", {30'd0, stall_if_id, freeze}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t27 post rst", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 16'd0);

    // Long freeze to drive the stall counter into saturation.
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step("s1 ld3",      1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 6'd0, 1'b0, 16'd0);
    drv(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("s2 ld3 mem",  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 16'd0);
    dmem_ready = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat 65534", {16'd0, stall_cnt}, 32'd65534);
    for (int i = 0; i < 6; i++) begin
      step("sat hold", 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 16'hFFFF);
    end
    dmem_ready = 1'b1;
    step("sat release", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 16'hFFFF);

    chk("queue empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
